// File: rtl/sum_serie.sv
// sum_serie: digit-serial adder, DIGIT bits of a+b+cin per cycle over STEPS = WIDTH/DIGIT cycles.
// Latency: out_valid rises STEPS+1 rising edges after the accepting edge.
// Backpressure: one operation in flight; result is held in DONE until out_ready, in_ready low meanwhile.
// Optional feature: define SUM_SUB_EN to add the sub port (s = a - b as a + ~b + 1).
module sum_serie #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUM_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               ov_q, ov_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               rdy_en_q;

   logic [DIGIT:0]       dsum;
   logic [WIDTH+DIGIT-1:0] s_cat;

   // Digit adder on the low DIGIT bits of the operand shift registers.
   always_comb begin
      dsum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      s_cat = {dsum[DIGIT-1:0], s_q};
   end

   // Next-state and datapath updates; the extra DONE cycle before out_valid gives STEPS+1 latency.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      ov_d    = ov_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid && rdy_en_q) begin
               a_d = a;
`ifdef SUM_SUB_EN
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = b;
               carry_d = cin;
`endif
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            s_d     = s_cat[WIDTH+DIGIT-1:DIGIT];
            carry_d = dsum[DIGIT];
            cout_d  = dsum[DIGIT];
            // carry into the digit MSB recovered from its sum bit, XOR carry out
            ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!ov_q) begin
               ov_d = 1'b1;
            end else if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ov_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         ov_q    <= ov_d;
         cnt_q   <= cnt_d;
      end
   end

   // Keeps in_ready low during reset and until the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
      end
   end

   assign in_ready  = rdy_en_q && (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = ov_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sum_serie.sv
// Bench for sum_serie: instance 0 is WIDTH=8/DIGIT=1, instance 1 is WIDTH=8/DIGIT=4.
// Directed table plus random operands checked against an arithmetic reference model.
// Also exercises output backpressure, ignored in_valid while busy, and reset mid-operation.
module tb_sum_serie;

   logic       clk;
   logic       rst_n;
   logic       in_valid_t  [2];
   logic       in_ready_t  [2];
   logic [7:0] a_t         [2];
   logic [7:0] b_t         [2];
   logic       cin_t       [2];
   logic       sub_t       [2];
   logic       out_valid_t [2];
   logic       out_ready_t [2];
   logic [7:0] s_t         [2];
   logic       cout_t      [2];
   logic       ovf_t       [2];
   logic       busy_t      [2];

   int errors = 0;
   int checks = 0;

`ifdef SUM_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   sum_serie #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_t[0]), .in_ready(in_ready_t[0]),
      .a(a_t[0]), .b(b_t[0]), .cin(cin_t[0]),
`ifdef SUM_SUB_EN
      .sub(sub_t[0]),
`endif
      .out_valid(out_valid_t[0]), .out_ready(out_ready_t[0]),
      .s(s_t[0]), .cout(cout_t[0]), .ovf(ovf_t[0]), .busy(busy_t[0])
   );

   sum_serie #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_t[1]), .in_ready(in_ready_t[1]),
      .a(a_t[1]), .b(b_t[1]), .cin(cin_t[1]),
`ifdef SUM_SUB_EN
      .sub(sub_t[1]),
`endif
      .out_valid(out_valid_t[1]), .out_ready(out_ready_t[1]),
      .s(s_t[1]), .cout(cout_t[1]), .ovf(ovf_t[1]), .busy(busy_t[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         d;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] es;
      logic       ec;
      logic       eo;
      int         lat;
      int         hold;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic, overflow from the operand/result sign rule.
   function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                        input logic cv, input logic sv);
      logic [7:0]  be;
      logic        ce;
      int unsigned full;
      logic [7:0]  rs;
      logic        ro;
      be = bv;
      ce = cv;
      if (sv && SUB_EN) begin
         be = ~bv;
         ce = 1'b1;
      end
      full = 32'(av) + 32'(be) + 32'(ce);
      rs   = full[7:0];
      ro   = (av[7] == be[7]) && (rs[7] != av[7]);
      return {ro, full[8], rs};
   endfunction

   task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input int elat, input int hold, input string nm);
      int n;
      int lat;
      n = 0;
      while (!in_ready_t[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({nm, " in_ready_idle"}, in_ready_t[d], 1);
      in_valid_t[d] = 1'b1;
      a_t[d] = av;
      b_t[d] = bv;
      cin_t[d] = cv;
      sub_t[d] = sv;
      @(posedge clk);
      #1;
      check({nm, " busy_run"}, busy_t[d], 1);
      check({nm, " in_ready_run"}, in_ready_t[d], 0);
      // junk operands while busy must be ignored
      a_t[d] = 8'($urandom);
      b_t[d] = 8'($urandom);
      cin_t[d] = 1'($urandom);
      sub_t[d] = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid_t[d] && lat < 40);
      in_valid_t[d] = 1'b0;
      check({nm, " out_valid"}, out_valid_t[d], 1);
      check({nm, " latency"}, lat, elat);
      check({nm, " s"}, s_t[d], es);
      check({nm, " cout"}, cout_t[d], ec);
      check({nm, " ovf"}, ovf_t[d], eo);
      check({nm, " busy_done"}, busy_t[d], 0);
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
         end
         check({nm, " hold_valid"}, out_valid_t[d], 1);
         check({nm, " hold_s"}, s_t[d], es);
         check({nm, " hold_cout"}, cout_t[d], ec);
         check({nm, " hold_ovf"}, ovf_t[d], eo);
         check({nm, " hold_in_ready"}, in_ready_t[d], 0);
      end
      out_ready_t[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_t[d] = 1'b0;
      check({nm, " valid_fall"}, out_valid_t[d], 0);
      check({nm, " ready_back"}, in_ready_t[d], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] m;
      int         seen;
      int         dd;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic       rsub;

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid_t[k] = 1'b0;
         a_t[k] = 8'h00;
         b_t[k] = 8'h00;
         cin_t[k] = 1'b0;
         sub_t[k] = 1'b0;
         out_ready_t[k] = 1'b0;
      end

      tbl.push_back(vec_t'{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9, 0});
      tbl.push_back(vec_t'{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 9, 0});
      tbl.push_back(vec_t'{1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3, 0});
      tbl.push_back(vec_t'{0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 9, 5});
      tbl.push_back(vec_t'{1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3, 2});
      tbl.push_back(vec_t'{1, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 3, 0});
`ifdef SUM_SUB_EN
      tbl.push_back(vec_t'{0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 9, 0});
      tbl.push_back(vec_t'{0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 9, 0});
      tbl.push_back(vec_t'{1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 3, 0});
`endif

      // reset state
      #3;
      for (int k = 0; k < 2; k++) begin
         check("rst in_ready", in_ready_t[k], 0);
         check("rst out_valid", out_valid_t[k], 0);
         check("rst busy", busy_t[k], 0);
         check("rst s", s_t[k], 0);
         check("rst cout", cout_t[k], 0);
         check("rst ovf", ovf_t[k], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst in_ready0", in_ready_t[0], 1);
      check("post_rst in_ready1", in_ready_t[1], 1);

      // directed table
      foreach (tbl[i]) begin
         do_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
               tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].lat, tbl[i].hold,
               $sformatf("vec%0d", i));
      end

      // random operands against the reference model
      for (int i = 0; i < 40; i++) begin
         dd   = int'($urandom_range(0, 1));
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
         rsub = SUB_EN ? 1'($urandom) : 1'b0;
         m    = model(ra, rb, rc, rsub);
         do_op(dd, ra, rb, rc, rsub, m[7:0], m[8], m[9], (dd == 0) ? 9 : 3,
               int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
      end

      // reset pulse at RUN step 3 aborts without an out_valid pulse
      @(negedge clk);
      in_valid_t[0] = 1'b1;
      a_t[0] = 8'hFF;
      b_t[0] = 8'hFF;
      cin_t[0] = 1'b1;
      sub_t[0] = 1'b0;
      @(posedge clk);
      #1;
      in_valid_t[0] = 1'b0;
      check("abort busy", busy_t[0], 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort out_valid", out_valid_t[0], 0);
      check("abort s", s_t[0], 0);
      check("abort cout", cout_t[0], 0);
      check("abort busy_rst", busy_t[0], 0);
      check("abort in_ready_rst", in_ready_t[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort in_ready_release", in_ready_t[0], 1);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid_t[0]) seen++;
      end
      check("abort no_valid", seen, 0);
      check("abort s_after", s_t[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sum_serie.md
SUM_SERIE -- requirements
Module: sum_serie

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (>=2).
REQ-002 The block SHALL have parameter DIGIT, default 1, meaning bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT; STEPS = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operands a, b, cin (and sub) valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have ports a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-008 The block SHALL have port cin  input  1  carry in (add mode).
REQ-009 The block SHALL have port sub  input  1  1 = subtract a-b; present only when SUM_SUB_EN is defined.
REQ-010 The block SHALL have port out_valid  output  1  result s, cout, ovf valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port s  output  WIDTH  sum/difference.
REQ-013 The block SHALL have port cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-014 The block SHALL have port ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-015 The block SHALL have port busy  output  1  high in RUN state.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-017 In IDLE, a cycle with in_valid=1 SHALL latch a, b, cin (and sub) into internal shift registers, clear step counter, go to RUN.
REQ-018 In RUN, each cycle SHALL add the DIGIT LSBs of the operand registers plus the stored carry, shift the DIGIT result bits into the result register from the MSB end, and update carry.
REQ-019 After STEPS RUN cycles, the FSM SHALL go to DONE; out_valid SHALL rise exactly STEPS+1 rising edges after the accepting edge.
REQ-020 In DONE, s, cout, ovf SHALL stay stable while out_ready=0; on out_valid=1 and out_ready=1, the FSM SHALL return to IDLE and out_valid SHALL fall next cycle.
REQ-021 No new operand SHALL be accepted in RUN or DONE; in_valid there SHALL be ignored.
REQ-022 s SHALL equal (a + b + cin) mod 2^WIDTH; cout SHALL equal bit WIDTH of the full sum.
REQ-023 The step counter SHALL be sized ceil(log2(STEPS+1)) bits and SHALL not wrap within an operation.
REQ-024 When DIGIT = WIDTH, the block SHALL spend one RUN cycle (STEPS=1).

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously go to IDLE and clear s, cout, ovf, out_valid, busy, carry and counter to 0.
REQ-026 The block SHALL force in_ready to 0 while rst_n=0, and it SHALL rise in the first cycle after release.
REQ-027 A reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse.

Configuration
REQ-028 With SUM_SUB_EN defined, sub=1 at acceptance SHALL compute s = a + ~b + 1, with cin ignored; sub=0 SHALL behave as add.
REQ-029 Without SUM_SUB_EN, the sub port and inversion logic SHALL be absent and the block SHALL add only.

Verification
REQ-030 For WIDTH=8, DIGIT=1, the bench SHALL cover a=FF, b=01, cin=0 -> s=00, cout=1, ovf=0, out_valid 9 edges after accept.
REQ-031 For WIDTH=8, DIGIT=1, the bench SHALL cover a=7F, b=01, cin=0 -> s=80, cout=0, ovf=1.
REQ-032 For WIDTH=8, DIGIT=4, the bench SHALL cover a=A5, b=5A, cin=1 -> s=00, cout=1, ovf=0, out_valid 3 edges after accept.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE -> s, cout, ovf unchanged, in_ready=0, then handshake -> IDLE.
REQ-034 The bench SHALL pulse rst_n low at RUN step 3 -> out_valid stays 0, s=00, in_ready=1 after release.
REQ-035 With SUM_SUB_EN, the bench SHALL cover a=05, b=07, sub=1 -> s=FE, cout=0, ovf=0; and a=80, b=01, sub=1 -> s=7F, cout=1, ovf=1.
